// File: rtl/qbert_jump_ctrl.sv
//------------------------------------------------------------------------------
// Module : qbert_jump_ctrl
// Brief  : Q*bert hop sequencer; walks the sprite centre cube to cube, falls off edges.
// Rev    : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module qbert_jump_ctrl #(
  parameter int          N_ROWS   = 7,
  parameter logic [10:0] X_TOP    = 11'd100,
  parameter logic [9:0]  Y_TOP    = 10'd240,
  parameter logic [10:0] XSTEP    = 11'd60,
  parameter logic [9:0]  YHALF    = 10'd30,
  parameter int          X_MAX    = 799,
  parameter int          STEP_DIV = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        jump_req,
  input  logic [1:0]  jump_dir,
  input  logic        respawn,
  output logic        jump_ack,
  output logic        busy,
  output logic [10:0] qbert_x,
  output logic [9:0]  qbert_y,
  output logic [2:0]  cube_row,
  output logic [2:0]  cube_col,
  output logic        landed,
  output logic        fell
);

  generate
    if (X_MAX < 1 || X_MAX > 2047 || STEP_DIV < 1 || N_ROWS < 1 || N_ROWS > 8 ||
        XSTEP == 11'd0 || YHALF == 10'd0) begin : g_param_check
      $error("qbert_jump_ctrl: illegal parameter set");
    end
  endgenerate

  localparam int          CW           = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] c_cnt_last = CW'(STEP_DIV - 1);
  localparam logic [10:0] c_x_max      = 11'(X_MAX);
  localparam logic [10:0] c_shift_last = {1'b0, YHALF} - 11'd1;
  localparam logic [10:0] c_hop_last   = XSTEP - 11'd1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_HOP   = 3'd2,
    S_FALL  = 3'd3,
    S_DEAD  = 3'd4
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [10:0]     r_mv;
  logic            r_dy_pos;
  logic            r_dx_pos;
  logic            r_valid;
  logic [2:0]      r_trow;
  logic [2:0]      r_tcol;

  logic            w_tick;
  logic signed [3:0] w_row_s, w_col_s, w_trow, w_tcol;
  logic            w_tvalid;

  assign w_tick  = (r_state != S_IDLE) && (r_cnt == c_cnt_last);
  assign w_row_s = $signed({1'b0, cube_row});
  assign w_col_s = $signed({1'b0, cube_col});

  // Target cube in signed 4-bit space so off-pyramid moves show up as negative or oversize.
  always_comb begin
    w_trow = jump_dir[1] ? (w_row_s - 4'sd1) : (w_row_s + 4'sd1);
    case (jump_dir)
      2'd1:    w_tcol = w_col_s + 4'sd1;
      2'd2:    w_tcol = w_col_s - 4'sd1;
      default: w_tcol = w_col_s;
    endcase
    w_tvalid = (w_trow >= 4'sd0) && (int'(w_trow) < N_ROWS) &&
               (w_tcol >= 4'sd0) && (w_tcol <= w_trow);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_mv     <= '0;
      r_dy_pos <= 1'b0;
      r_dx_pos <= 1'b0;
      r_valid  <= 1'b0;
      r_trow   <= '0;
      r_tcol   <= '0;
      jump_ack <= 1'b0;
      busy     <= 1'b0;
      qbert_x  <= X_TOP;
      qbert_y  <= Y_TOP;
      cube_row <= '0;
      cube_col <= '0;
      landed   <= 1'b0;
      fell     <= 1'b0;
    end else begin
      jump_ack <= 1'b0;
      landed   <= 1'b0;
      fell     <= 1'b0;

      if (r_state == S_IDLE || w_tick) r_cnt <= '0;
      else                             r_cnt <= r_cnt + CW'(1);

      case (r_state)
        S_IDLE: begin
          if (jump_req) begin
            r_trow   <= w_trow[2:0];
            r_tcol   <= w_tcol[2:0];
            r_valid  <= w_tvalid;
            r_dy_pos <= jump_dir[0];
            r_dx_pos <= ~jump_dir[1];
            r_mv     <= '0;
            jump_ack <= 1'b1;
            busy     <= 1'b1;
            r_state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_tick) begin
            qbert_y <= r_dy_pos ? (qbert_y + 10'd1) : (qbert_y - 10'd1);
            if (r_mv == c_shift_last) begin
              r_mv    <= '0;
              r_state <= S_HOP;
            end else begin
              r_mv <= r_mv + 11'd1;
            end
          end
        end
        S_HOP: begin
          if (w_tick) begin
            qbert_x <= r_dx_pos ? (qbert_x + 11'd1) : (qbert_x - 11'd1);
            if (r_mv == c_hop_last) begin
              r_mv <= '0;
              if (r_valid) begin
                cube_row <= r_trow;
                cube_col <= r_tcol;
                landed   <= 1'b1;
                busy     <= 1'b0;
                r_state  <= S_IDLE;
              end else begin
                r_state  <= S_FALL;
              end
            end else begin
              r_mv <= r_mv + 11'd1;
            end
          end
        end
        S_FALL: begin
          // Saturate at the bottom of the screen; the arrival step raises fell.
          if (w_tick) begin
            if (qbert_x >= c_x_max - 11'd1) begin
              qbert_x <= c_x_max;
              fell    <= 1'b1;
              r_state <= S_DEAD;
            end else begin
              qbert_x <= qbert_x + 11'd1;
            end
          end
        end
        S_DEAD: begin
          if (respawn) begin
            cube_row <= '0;
            cube_col <= '0;
            qbert_x  <= X_TOP;
            qbert_y  <= Y_TOP;
            busy     <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_qbert_jump_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_qbert_jump_ctrl
// Brief  : Bench for qbert_jump_ctrl; two instances (STEP_DIV 1 and 20) against a trajectory model.
// Rev    : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_qbert_jump_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, req_a, resp_a, rst_b, req_b, resp_b;
  logic [1:0]  dir_a, dir_b;
  logic        ack_a, busy_a, land_a, fell_a, ack_b, busy_b, land_b, fell_b;
  logic [10:0] x_a, x_b;
  logic [9:0]  y_a, y_b;
  logic [2:0]  row_a, col_a, row_b, col_b;

  qbert_jump_ctrl #(.STEP_DIV(1)) dut_a (
    .clk(clk), .reset(rst_a), .jump_req(req_a), .jump_dir(dir_a), .respawn(resp_a),
    .jump_ack(ack_a), .busy(busy_a), .qbert_x(x_a), .qbert_y(y_a),
    .cube_row(row_a), .cube_col(col_a), .landed(land_a), .fell(fell_a));

  qbert_jump_ctrl #(.STEP_DIV(20)) dut_b (
    .clk(clk), .reset(rst_b), .jump_req(req_b), .jump_dir(dir_b), .respawn(resp_b),
    .jump_ack(ack_b), .busy(busy_b), .qbert_x(x_b), .qbert_y(y_b),
    .cube_row(row_b), .cube_col(col_b), .landed(land_b), .fell(fell_b));

  int checks = 0;
  int errors = 0;
  int m_row[2];
  int m_col[2];
  int m_dead_y[2];

  logic [10:0] s_x;
  logic [9:0]  s_y;
  logic [2:0]  s_row, s_col;
  logic        s_ack, s_busy, s_land, s_fell;

  task automatic sample(input int sel);
    if (sel == 0) begin
      s_x = x_a; s_y = y_a; s_row = row_a; s_col = col_a;
      s_ack = ack_a; s_busy = busy_a; s_land = land_a; s_fell = fell_a;
    end else begin
      s_x = x_b; s_y = y_b; s_row = row_b; s_col = col_b;
      s_ack = ack_b; s_busy = busy_b; s_land = land_b; s_fell = fell_b;
    end
  endtask

  task automatic drive(input int sel, input logic req, input logic [1:0] dir, input logic resp);
    if (sel == 0) begin req_a = req; dir_a = dir; resp_a = resp; end
    else          begin req_b = req; dir_b = dir; resp_b = resp; end
  endtask

  // One full jump from the model's current cube, checked every cycle until landed or fell.
  task automatic run_jump(input int sel, input int dir, input bit hold, output bit fell_o);
    int d, orow, ocol, x0, y0, tr, tc, sy, sx, xh, nfall, n, ex, ey, k;
    bit valid, done, el, ef;
    d     = (sel == 0) ? 1 : 20;
    orow  = m_row[sel];
    ocol  = m_col[sel];
    x0    = 100 + orow * 60;
    y0    = 240 + (2 * ocol - orow) * 30;
    tr    = orow + ((dir < 2) ? 1 : -1);
    tc    = ocol + ((dir == 1) ? 1 : ((dir == 2) ? -1 : 0));
    valid = (tr >= 0) && (tr < 7) && (tc >= 0) && (tc <= tr);
    sy    = (dir % 2 == 1) ? 1 : -1;
    sx    = (dir < 2) ? 1 : -1;
    xh    = x0 + sx * 60;
    nfall = 90 + (799 - xh);
    done  = 0;
    k     = 0;
    drive(sel, 1'b1, 2'(dir), 1'b0);
    while (!done) begin
      @(posedge clk); #1;
      sample(sel);
      drive(sel, hold, 2'($urandom_range(0, 3)), 1'b0);
      n  = k / d;
      ey = y0 + sy * ((n < 30) ? n : 30);
      if (n <= 30)      ex = x0;
      else if (n <= 90) ex = x0 + sx * (n - 30);
      else              ex = (xh + n - 90 > 799) ? 799 : (xh + n - 90);
      el = valid && (k == 90 * d);
      ef = !valid && (k == nfall * d);
      checks += 8;
      if (s_x !== 11'(ex)) begin errors++; $display("FAIL jump_x dut%0d dir%0d k=%0d got %0d want %0d", sel, dir, k, s_x, ex); end
      if (s_y !== 10'(ey)) begin errors++; $display("FAIL jump_y dut%0d dir%0d k=%0d got %0d want %0d", sel, dir, k, s_y, ey); end
      if (s_ack !== (k == 0)) begin errors++; $display("FAIL jump_ack dut%0d k=%0d got %b want %b", sel, k, s_ack, (k == 0)); end
      if (s_land !== el) begin errors++; $display("FAIL landed dut%0d k=%0d got %b want %b", sel, k, s_land, el); end
      if (s_fell !== ef) begin errors++; $display("FAIL fell dut%0d k=%0d got %b want %b", sel, k, s_fell, ef); end
      if (s_busy !== !el) begin errors++; $display("FAIL busy dut%0d k=%0d got %b want %b", sel, k, s_busy, !el); end
      if (s_row !== 3'(el ? tr : orow)) begin errors++; $display("FAIL cube_row dut%0d k=%0d got %0d want %0d", sel, k, s_row, el ? tr : orow); end
      if (s_col !== 3'(el ? tc : ocol)) begin errors++; $display("FAIL cube_col dut%0d k=%0d got %0d want %0d", sel, k, s_col, el ? tc : ocol); end
      done = el || ef;
      k++;
    end
    if (valid) begin
      m_row[sel] = tr;
      m_col[sel] = tc;
    end
    m_dead_y[sel] = y0 + sy * 30;
    fell_o = !valid;
  endtask

  // DEAD ignores jumps; respawn returns to the apex and IDLE.
  task automatic test_dead_respawn(input int sel);
    for (int i = 0; i < 4; i++) begin
      drive(sel, 1'b1, 2'($urandom_range(0, 3)), 1'b0);
      @(posedge clk); #1;
      sample(sel);
      checks += 4;
      if (s_ack !== 1'b0) begin errors++; $display("FAIL dead_ack got %b want 0", s_ack); end
      if (s_busy !== 1'b1) begin errors++; $display("FAIL dead_busy got %b want 1", s_busy); end
      if (s_x !== 11'd799 || s_y !== 10'(m_dead_y[sel])) begin errors++; $display("FAIL dead_pos got %0d,%0d want 799,%0d", s_x, s_y, m_dead_y[sel]); end
      if (s_fell !== 1'b0) begin errors++; $display("FAIL dead_fell_once got %b want 0", s_fell); end
    end
    drive(sel, 1'b0, 2'd0, 1'b1);
    @(posedge clk); #1;
    drive(sel, 1'b0, 2'd0, 1'b0);
    sample(sel);
    checks += 3;
    if (s_x !== 11'd100 || s_y !== 10'd240) begin errors++; $display("FAIL respawn_pos got %0d,%0d want 100,240", s_x, s_y); end
    if (s_row !== 3'd0 || s_col !== 3'd0) begin errors++; $display("FAIL respawn_cube got %0d,%0d want 0,0", s_row, s_col); end
    if (s_busy !== 1'b0) begin errors++; $display("FAIL respawn_busy got %b want 0", s_busy); end
    m_row[sel] = 0;
    m_col[sel] = 0;
  endtask

  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0;
    drive(0, 1'b0, 2'd0, 1'b0);
    drive(1, 1'b0, 2'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    sample(0);
    checks += 4;
    if (s_x !== 11'd100 || s_y !== 10'd240) begin errors++; $display("FAIL reset_pos got %0d,%0d want 100,240", s_x, s_y); end
    if (s_row !== 3'd0 || s_col !== 3'd0) begin errors++; $display("FAIL reset_cube got %0d,%0d want 0,0", s_row, s_col); end
    if ({s_ack, s_busy, s_land, s_fell} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", {s_ack, s_busy, s_land, s_fell}); end
    sample(1);
    if (s_x !== 11'd100 || s_y !== 10'd240 || s_busy !== 1'b0) begin errors++; $display("FAIL reset_b got %0d,%0d,%b want 100,240,0", s_x, s_y, s_busy); end
    rst_a = 1'b1; rst_b = 1'b1;
    m_row = '{0, 0};
    m_col = '{0, 0};
  endtask

  task automatic test_basic_hops();
    bit f;
    run_jump(0, 1, 1'b0, f);
    run_jump(0, 2, 1'b0, f);
  endtask

  task automatic test_fall_off_top();
    bit f;
    run_jump(0, 3, 1'b0, f);
    test_dead_respawn(0);
  endtask

  task automatic test_walk_down();
    bit f;
    for (int i = 0; i < 6; i++) run_jump(0, 0, 1'b0, f);
    // respawn outside DEAD must not move anything
    drive(0, 1'b0, 2'd0, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
      sample(0);
      checks += 2;
      if (s_x !== 11'd460 || s_y !== 10'd60) begin errors++; $display("FAIL respawn_ignored_pos got %0d,%0d want 460,60", s_x, s_y); end
      if (s_row !== 3'd6 || s_busy !== 1'b0) begin errors++; $display("FAIL respawn_ignored_state got row %0d busy %b want 6,0", s_row, s_busy); end
    end
    drive(0, 1'b0, 2'd0, 1'b0);
    run_jump(0, 0, 1'b0, f);
    test_dead_respawn(0);
  endtask

  task automatic test_held_req();
    bit f;
    run_jump(0, 1, 1'b1, f);
    run_jump(0, 2, 1'b1, f);
    drive(0, 1'b0, 2'd0, 1'b0);
    @(posedge clk); #1;
    sample(0);
    checks += 2;
    if (s_busy !== 1'b0 || s_ack !== 1'b0) begin errors++; $display("FAIL held_req_after got busy %b ack %b want 0,0", s_busy, s_ack); end
    if (s_x !== 11'd100 || s_y !== 10'd240) begin errors++; $display("FAIL held_req_pos got %0d,%0d want 100,240", s_x, s_y); end
  endtask

  task automatic test_random_walk();
    bit f;
    for (int i = 0; i < 16; i++) begin
      run_jump(0, int'($urandom_range(0, 3)), 1'b0, f);
      if (f) test_dead_respawn(0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end
  endtask

  task automatic test_reset_mid_hop();
    bit f;
    drive(1, 1'b1, 2'd1, 1'b0);
    @(posedge clk); #1;
    drive(1, 1'b0, 2'd0, 1'b0);
    sample(1);
    checks++;
    if (s_ack !== 1'b1) begin errors++; $display("FAIL b_ack got %b want 1", s_ack); end
    repeat (800) @(posedge clk);
    #1;
    sample(1);
    checks++;
    if (s_x !== 11'd110 || s_y !== 10'd270) begin errors++; $display("FAIL b_mid_hop got %0d,%0d want 110,270", s_x, s_y); end
    #3 rst_b = 1'b0;
    #1;
    sample(1);
    checks += 2;
    if (s_x !== 11'd100 || s_y !== 10'd240 || s_busy !== 1'b0) begin errors++; $display("FAIL b_async_reset got %0d,%0d,%b want 100,240,0", s_x, s_y, s_busy); end
    if ({s_land, s_fell, s_row, s_col} !== 8'd0) begin errors++; $display("FAIL b_async_reset_flags got %b want 0", {s_land, s_fell, s_row, s_col}); end
    #2 rst_b = 1'b1;
    @(posedge clk); #1;
    sample(1);
    checks++;
    if (s_busy !== 1'b0 || s_land !== 1'b0 || s_x !== 11'd100) begin errors++; $display("FAIL b_post_reset got busy %b landed %b x %0d want 0,0,100", s_busy, s_land, s_x); end
    m_row[1] = 0;
    m_col[1] = 0;
    run_jump(1, 1, 1'b0, f);
  endtask

  initial begin
    test_reset();
    test_basic_hops();
    test_fall_off_top();
    test_walk_down();
    test_held_req();
    test_random_walk();
    test_reset_mid_hop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
